// File: rtl/oled_pkg.sv
// -----------------------------------------------------------------------------
// oled_pkg
// Shared definitions for the OLED text path: the blank character, the
// streamer state encoding and an index-width helper used to size the
// line/column address ports.
// -----------------------------------------------------------------------------
package oled_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_LOW = 2'd2
  } oled_state_e;

  // Address width for n entries, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/oled_text_streamer_if.sv
// -----------------------------------------------------------------------------
// oled_text_streamer_if
// Groups the streamer's character-write port, frame control and the byte
// handshake towards oled_controller.
//   wr_en/wr_line/wr_col/wr_char : buffer write port
//   start/busy/frame_done        : frame control and status
//   tx_data/tx_valid/tx_done     : 4-phase byte handshake (sdin/d_valid/txDone)
// master = the streamer, slave = everything driving it / consuming its bytes.
// -----------------------------------------------------------------------------
interface oled_text_streamer_if #(
  parameter int LINES = 4,
  parameter int COLS  = 16
);

  localparam int LW = oled_pkg::idx_width(LINES);
  localparam int CW = oled_pkg::idx_width(COLS);

  logic          wr_en;
  logic [LW-1:0] wr_line;
  logic [CW-1:0] wr_col;
  logic [7:0]    wr_char;
  logic          start;
  logic          busy;
  logic          frame_done;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_done;

  modport master (
    input  wr_en, wr_line, wr_col, wr_char, start, tx_done,
    output busy, frame_done, tx_data, tx_valid
  );

  modport slave (
    output wr_en, wr_line, wr_col, wr_char, start, tx_done,
    input  busy, frame_done, tx_data, tx_valid
  );

endinterface

// File: rtl/oled_char_buffer.sv
// -----------------------------------------------------------------------------
// oled_char_buffer
// LINES x COLS array of ASCII characters held in flops, one write port and
// one combinational read port.
//   clock, reset        : clock, asynchronous active-high reset (fills spaces)
//   wr_en/wr_line/wr_col/wr_char : write one character; out-of-range ignored
//   rd_line/rd_col -> rd_char    : combinational read
// -----------------------------------------------------------------------------
module oled_char_buffer
  import oled_pkg::*;
#(
  parameter int LINES = 4,
  parameter int COLS  = 16,
  parameter int LW    = 2,
  parameter int CW    = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [LW-1:0] wr_line,
  input  logic [CW-1:0] wr_col,
  input  logic [7:0]    wr_char,
  input  logic [LW-1:0] rd_line,
  input  logic [CW-1:0] rd_col,
  output logic [7:0]    rd_char
);

  // One extra bit so LINES/COLS themselves are representable for the compare.
  localparam logic [LW:0] LINE_LIMIT = (LW+1)'(LINES);
  localparam logic [CW:0] COL_LIMIT  = (CW+1)'(COLS);

  logic [7:0] mem_q [LINES][COLS];
  logic       wr_ok;

  // Non-power-of-two geometries leave unused codes; those writes are dropped.
  assign wr_ok = wr_en && ({1'b0, wr_line} < LINE_LIMIT)
                       && ({1'b0, wr_col}  < COL_LIMIT);

  // NOTE: this array is reset on purpose -- a freshly reset display must show
  // blank text, so every cell is forced to a space rather than left undefined.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < LINES; l++) begin
        for (int c = 0; c < COLS; c++) begin
          mem_q[l][c] <= ASCII_SPACE;
        end
      end
    end else if (wr_ok) begin
      mem_q[wr_line][wr_col] <= wr_char;
    end
  end

  assign rd_char = mem_q[rd_line][rd_col];

endmodule

// File: rtl/oled_text_streamer.sv
// -----------------------------------------------------------------------------
// oled_text_streamer
// Holds a LINES x COLS text buffer and streams it byte by byte to
// oled_controller using a 4-phase tx_valid/tx_done handshake.
//   clock, reset : clock, asynchronous active-high reset (aborts any frame)
//   bus (master) : write port, start/busy/frame_done, tx_data/tx_valid/tx_done
// Parameters: START_ON_RESET launches one frame right after reset release;
// AUTO_REFRESH repeats frames forever once the first one has started.
// -----------------------------------------------------------------------------
module oled_text_streamer
  import oled_pkg::*;
#(
  parameter int LINES          = 4,
  parameter int COLS           = 16,
  parameter int START_ON_RESET = 1,
  parameter int AUTO_REFRESH   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  oled_text_streamer_if.master  bus
);

  localparam int LW = idx_width(LINES);
  localparam int CW = idx_width(COLS);
  localparam logic [LW-1:0] LAST_LINE = LW'(LINES - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
  localparam bit AUTO_START  = (START_ON_RESET != 0);
  localparam bit AUTO_REPEAT = (AUTO_REFRESH != 0);

  oled_state_e   state_q, state_d;
  logic [LW-1:0] line_q, line_d;
  logic [CW-1:0] col_q, col_d;
  logic          end_q, end_d;     // pointer has moved past the last byte
  logic [7:0]    data_q, data_d;
  logic          fdone_q, fdone_d;
  logic          first_q;          // high only until the first post-reset edge
  logic          load;
  logic [7:0]    rd_char;

  // The read address follows the next pointer, so the byte latched on a
  // load edge is the buffer content before any write on that same edge.
  oled_char_buffer #(
    .LINES (LINES),
    .COLS  (COLS),
    .LW    (LW),
    .CW    (CW)
  ) u_buffer (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (bus.wr_en),
    .wr_line (bus.wr_line),
    .wr_col  (bus.wr_col),
    .wr_char (bus.wr_char),
    .rd_line (line_d),
    .rd_col  (col_d),
    .rd_char (rd_char)
  );

  // NOTE: every register here uses non-blocking assignment so all of them
  // update together from the values present before the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      line_q  <= '0;
      col_q   <= '0;
      end_q   <= 1'b0;
      data_q  <= 8'h00;
      fdone_q <= 1'b0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      col_q   <= col_d;
      end_q   <= end_d;
      data_q  <= data_d;
      fdone_q <= fdone_d;
      first_q <= 1'b0;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    col_d   = col_q;
    end_d   = end_q;
    data_d  = data_q;
    fdone_d = 1'b0;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        // A start is only honoured once the controller has released tx_done.
        if ((bus.start || (first_q && AUTO_START)) && !bus.tx_done) begin
          line_d  = '0;
          col_d   = '0;
          end_d   = 1'b0;
          load    = 1'b1;
          state_d = SEND;
        end
      end

      SEND: begin
        if (bus.tx_done) begin
          state_d = WAIT_LOW;
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (line_q == LAST_LINE) begin
              end_d = 1'b1;
            end else begin
              line_d = line_q + LW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end

      WAIT_LOW: begin
        if (!bus.tx_done) begin
          if (end_q) begin
            fdone_d = 1'b1;
            line_d  = '0;
            col_d   = '0;
            end_d   = 1'b0;
            if (AUTO_REPEAT) begin
              load    = 1'b1;
              state_d = SEND;
            end else begin
              state_d = IDLE;
            end
          end else begin
            load    = 1'b1;
            state_d = SEND;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // tx_data only changes when tx_valid rises, so later buffer writes to
    // the in-flight position cannot disturb the byte being transferred.
    if (load) begin
      data_d = rd_char;
    end
  end

  // tx_valid/busy decode straight from the state register so an
  // asynchronous reset drops them immediately.
  assign bus.tx_valid   = (state_q == SEND);
  assign bus.busy       = (state_q != IDLE);
  assign bus.tx_data    = data_q;
  assign bus.frame_done = fdone_q;

endmodule

// File: tb/tb_oled_text_streamer.sv
// -----------------------------------------------------------------------------
// tb_oled_text_streamer
// Two streamers: dut_a (4x16, start on reset, single frames) and dut_b (2x3,
// no start on reset, auto refresh). Each has a randomised controller model
// that pops the expected (line, col) sequence from a scoreboard queue and
// compares the byte against a text-buffer model updated at every clock edge.
// -----------------------------------------------------------------------------
module tb_oled_text_streamer;
  import oled_pkg::*;

  typedef struct {
    int line;
    int col;
  } pos_t;

  logic clock = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clock = ~clock;

  oled_text_streamer_if #(.LINES(4), .COLS(16)) ifa ();
  oled_text_streamer_if #(.LINES(2), .COLS(3))  ifb ();

  oled_text_streamer #(
    .LINES(4), .COLS(16), .START_ON_RESET(1), .AUTO_REFRESH(0)
  ) dut_a (
    .clock (clock),
    .reset (rst_a),
    .bus   (ifa.master)
  );

  oled_text_streamer #(
    .LINES(2), .COLS(3), .START_ON_RESET(0), .AUTO_REFRESH(1)
  ) dut_b (
    .clock (clock),
    .reset (rst_b),
    .bus   (ifb.master)
  );

  int checks = 0;
  int errors = 0;

  // text-buffer models: *_prev is the content just before the latest edge
  logic [7:0] model_a [4][16];
  logic [7:0] prev_a  [4][16];
  logic [7:0] model_b [2][3];
  logic [7:0] prev_b  [2][3];

  pos_t q_a[$];
  pos_t q_b[$];

  // controller model state
  int ph_a = 0, dly_a = 0, hld_a = 0, bytes_a = 0, total_a = 0, fd_a = 0;
  int resp_min_a = 0, resp_max_a = 2, hold_min_a = 0, hold_max_a = 3;
  int last_idx_a = -1;
  logic [7:0] cap_a;
  logic [7:0] sent_a [64];
  pos_t p_a;

  int ph_b = 0, dly_b = 0, hld_b = 0, bytes_b = 0, total_b = 0, fd_b = 0;
  int resp_min_b = 0, resp_max_b = 2, hold_min_b = 0, hold_max_b = 3;
  bit run_b = 1'b0;
  logic [7:0] cap_b;
  logic [7:0] sent_b [6];
  pos_t p_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_frame_a();
    for (int l = 0; l < 4; l++)
      for (int c = 0; c < 16; c++)
        q_a.push_back('{l, c});
  endfunction

  function automatic void push_frame_b();
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < 3; c++)
        q_b.push_back('{l, c});
  endfunction

  // Buffer models: a write issued before an edge is visible after it.
  always @(posedge clock) begin
    prev_a = model_a;
    if (rst_a) begin
      foreach (model_a[l, c]) model_a[l][c] = 8'h20;
      prev_a = model_a;
    end else if (ifa.wr_en) begin
      model_a[ifa.wr_line][ifa.wr_col] = ifa.wr_char;
    end
    prev_b = model_b;
    if (rst_b) begin
      foreach (model_b[l, c]) model_b[l][c] = 8'h20;
      prev_b = model_b;
    end else if (ifb.wr_en && ifb.wr_col < 2'd3) begin
      model_b[ifb.wr_line][ifb.wr_col] = ifb.wr_char;
    end
  end

  // Controller + monitor for dut_a
  always @(negedge clock) begin
    if (rst_a) begin
      ph_a = 0; ifa.tx_done = 1'b0; bytes_a = 0; q_a.delete();
    end else begin
      if (ifa.frame_done) begin
        check("a_frame_len", bytes_a, 64);
        check("a_busy_at_done", ifa.busy, 0);
        fd_a++;
        bytes_a = 0;
      end
      case (ph_a)
        0: if (ifa.tx_valid) begin
          if (q_a.size() == 0) begin
            check("a_unexpected_byte", ifa.tx_valid, 0);
          end else begin
            p_a = q_a.pop_front();
            check("a_byte", ifa.tx_data, prev_a[p_a.line][p_a.col]);
            last_idx_a = p_a.line * 16 + p_a.col;
            sent_a[last_idx_a] = ifa.tx_data;
          end
          bytes_a++; total_a++;
          cap_a = ifa.tx_data;
          dly_a = $urandom_range(resp_max_a, resp_min_a);
          if (dly_a == 0) begin
            ifa.tx_done = 1'b1; hld_a = $urandom_range(hold_max_a, hold_min_a); ph_a = 2;
          end else ph_a = 1;
        end
        1: begin
          check("a_data_stable", {ifa.tx_valid, ifa.tx_data}, {1'b1, cap_a});
          dly_a--;
          if (dly_a == 0) begin
            ifa.tx_done = 1'b1; hld_a = $urandom_range(hold_max_a, hold_min_a); ph_a = 2;
          end
        end
        2: begin
          check("a_valid_low", ifa.tx_valid, 0);
          if (hld_a == 0) begin ifa.tx_done = 1'b0; ph_a = 0; end
          else hld_a--;
        end
        default: ph_a = 0;
      endcase
    end
  end

  // Controller + monitor for dut_b (auto refresh: refill one frame at a time)
  always @(negedge clock) begin
    if (rst_b) begin
      ph_b = 0; ifb.tx_done = 1'b0; bytes_b = 0; q_b.delete();
    end else begin
      if (ifb.frame_done) begin
        check("b_frame_len", bytes_b, 6);
        check("b_busy_at_done", ifb.busy, 1);
        fd_b++;
        bytes_b = 0;
      end
      case (ph_b)
        0: if (ifb.tx_valid) begin
          if (q_b.size() == 0 && run_b) push_frame_b();
          if (q_b.size() == 0) begin
            check("b_unexpected_byte", ifb.tx_valid, 0);
          end else begin
            p_b = q_b.pop_front();
            check("b_byte", ifb.tx_data, prev_b[p_b.line][p_b.col]);
            sent_b[p_b.line * 3 + p_b.col] = ifb.tx_data;
          end
          bytes_b++; total_b++;
          cap_b = ifb.tx_data;
          dly_b = $urandom_range(resp_max_b, resp_min_b);
          if (dly_b == 0) begin
            ifb.tx_done = 1'b1; hld_b = $urandom_range(hold_max_b, hold_min_b); ph_b = 2;
          end else ph_b = 1;
        end
        1: begin
          check("b_data_stable", {ifb.tx_valid, ifb.tx_data}, {1'b1, cap_b});
          dly_b--;
          if (dly_b == 0) begin
            ifb.tx_done = 1'b1; hld_b = $urandom_range(hold_max_b, hold_min_b); ph_b = 2;
          end
        end
        2: begin
          check("b_valid_low", ifb.tx_valid, 0);
          if (hld_b == 0) begin ifb.tx_done = 1'b0; ph_b = 0; end
          else hld_b--;
        end
        default: ph_b = 0;
      endcase
    end
  end

  // ---------------- stimulus tasks (called just after a negedge) ------------
  task automatic write_a(input int l, input int c, input logic [7:0] ch);
    ifa.wr_en = 1'b1; ifa.wr_line = 2'(l); ifa.wr_col = 4'(c); ifa.wr_char = ch;
    @(negedge clock);
    ifa.wr_en = 1'b0;
  endtask

  task automatic write_b(input int l, input int c, input logic [7:0] ch);
    ifb.wr_en = 1'b1; ifb.wr_line = 1'(l); ifb.wr_col = 2'(c); ifb.wr_char = ch;
    @(negedge clock);
    ifb.wr_en = 1'b0;
  endtask

  task automatic start_a();
    @(negedge clock);
    ifa.start = 1'b1;
    push_frame_a();
    @(negedge clock);
    ifa.start = 1'b0;
    check("a_start_latency", {ifa.busy, ifa.tx_valid}, 2'b11);
  endtask

  task automatic start_b();
    @(negedge clock);
    ifb.start = 1'b1;
    run_b = 1'b1;
    @(negedge clock);
    ifb.start = 1'b0;
    check("b_start_latency", {ifb.busy, ifb.tx_valid}, 2'b11);
  endtask

  task automatic wait_fd_a(input int target, input bit rw, input bit rs);
    int n = 0;
    while (fd_a < target && n < 5000) begin
      @(negedge clock);
      ifa.wr_en = 1'b0; ifa.start = 1'b0;
      if (rw && $urandom_range(3, 0) == 0) begin
        ifa.wr_en = 1'b1; ifa.wr_line = 2'($urandom); ifa.wr_col = 4'($urandom);
        ifa.wr_char = 8'($urandom_range(126, 32));
      end
      if (rs && ifa.busy && $urandom_range(15, 0) == 0) ifa.start = 1'b1;
      n++;
    end
    ifa.wr_en = 1'b0; ifa.start = 1'b0;
    check("a_frame_done_seen", (fd_a >= target) ? 1 : 0, 1);
  endtask

  task automatic wait_fd_b(input int target, input bit rw, input bit rs);
    int n = 0;
    while (fd_b < target && n < 3000) begin
      @(negedge clock);
      ifb.wr_en = 1'b0; ifb.start = 1'b0;
      if (rw && $urandom_range(2, 0) == 0) begin
        ifb.wr_en = 1'b1; ifb.wr_line = 1'($urandom); ifb.wr_col = 2'($urandom);
        ifb.wr_char = 8'($urandom_range(126, 32));
      end
      if (rs && $urandom_range(7, 0) == 0) ifb.start = 1'b1;
      n++;
    end
    ifb.wr_en = 1'b0; ifb.start = 1'b0;
    check("b_frame_done_seen", (fd_b >= target) ? 1 : 0, 1);
  endtask

  task automatic wait_idx_a(input int idx);
    int n = 0;
    while (last_idx_a != idx && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check("a_reach_idx", last_idx_a, idx);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] old13;
    int fd_snap;

    ifa.wr_en = 1'b0; ifa.wr_line = '0; ifa.wr_col = '0; ifa.wr_char = '0; ifa.start = 1'b0;
    ifb.wr_en = 1'b0; ifb.wr_line = '0; ifb.wr_col = '0; ifb.wr_char = '0; ifb.start = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    #12;
    check("a_rst_valid", ifa.tx_valid, 0);
    check("a_rst_busy", ifa.busy, 0);
    check("a_rst_data", ifa.tx_data, 8'h00);
    check("a_rst_fdone", ifa.frame_done, 0);
    check("b_rst_valid", ifb.tx_valid, 0);
    check("b_rst_busy", ifb.busy, 0);
    check("b_rst_data", ifb.tx_data, 8'h00);
    check("b_rst_fdone", ifb.frame_done, 0);

    repeat (3) @(negedge clock);
    rst_a = 1'b0;
    rst_b = 1'b0;
    push_frame_a();                 // dut_a starts a frame by itself

    // 1: power-on frame of 64 spaces, then silence
    wait_fd_a(1, 1'b0, 1'b0);
    repeat (20) @(negedge clock);
    check("a_single_frame", fd_a, 1);
    check("a_idle_after_frame", ifa.busy, 0);
    check("b_no_start_on_reset", {ifb.busy, ifb.tx_valid}, 2'b00);

    // 2: first and last characters
    write_a(0, 0, 8'h41);
    write_a(3, 15, 8'h5A);
    start_a();
    wait_fd_a(2, 1'b0, 1'b0);
    check("a_first_byte", sent_a[0], 8'h41);
    check("a_last_byte", sent_a[63], 8'h5A);
    check("a_middle_byte", sent_a[17], 8'h20);

    // 3: slow controller holding tx_done high for 5 cycles
    hold_min_a = 4; hold_max_a = 4; resp_max_a = 0;
    start_a();
    wait_fd_a(3, 1'b0, 1'b0);

    // 4: writes while a frame is streaming
    hold_min_a = 0; hold_max_a = 3; resp_min_a = 2; resp_max_a = 2;
    old13 = model_a[1][3];
    start_a();
    wait_idx_a(19);
    write_a(1, 3, 8'h2A);
    wait_idx_a(21);
    write_a(2, 0, 8'h7E);
    wait_fd_a(4, 1'b0, 1'b0);
    check("a_inflight_kept", sent_a[19], old13);
    check("a_ahead_write", sent_a[32], 8'h7E);

    // 5: random frames with random writes and ignored start pulses
    for (int i = 0; i < 3; i++) begin
      resp_min_a = 0; resp_max_a = $urandom_range(2, 0); hold_max_a = $urandom_range(3, 0);
      fd_snap = fd_a;
      start_a();
      wait_fd_a(fd_snap + 1, 1'b1, 1'b1);
    end
    repeat (10) @(negedge clock);
    check("a_no_queued_start", ifa.busy, 0);

    // 6: auto refresh, reset during byte 10
    write_b(0, 0, 8'h31);
    write_b(1, 2, 8'h32);
    write_b(0, 3, 8'h55);           // column out of range: ignored
    resp_min_b = 2; resp_max_b = 2;
    start_b();
    begin
      int n = 0;
      while (total_b < 10 && n < 500) begin
        @(negedge clock);
        n++;
      end
      check("b_reach_byte10", (total_b >= 10) ? 1 : 0, 1);
    end
    #1 rst_b = 1'b1;
    run_b = 1'b0;
    #1;
    check("b_reset_async", {ifb.busy, ifb.tx_valid, ifb.frame_done}, 3'b000);
    repeat (3) @(negedge clock);
    rst_b = 1'b0;
    repeat (20) @(negedge clock);
    check("b_idle_after_reset", ifb.busy, 0);
    check("b_no_done_on_abort", fd_b, 1);

    // 7: buffer came back as spaces
    resp_min_b = 0; resp_max_b = 1;
    fd_snap = fd_b;
    start_b();
    wait_fd_b(fd_snap + 1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) check("b_blank_after_reset", sent_b[i], 8'h20);

    // 8: continuous refresh with random writes and ignored starts
    resp_max_b = 2;
    wait_fd_b(fd_b + 4, 1'b1, 1'b1);
    check("b_still_busy", ifb.busy, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
